// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises the CPU inst and data memory ports onto one physical port
// Requests sampled together are served back to back and acknowledged in one shared cycle.
module mem_port_arbiter #(
  parameter int WIDTH      = 16,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_mem_read,
  input  logic             inst_mem_write,
  input  logic [1:0]       inst_mem_byte_enable,
  input  logic [WIDTH-1:0] inst_mem_addr,
  input  logic [WIDTH-1:0] inst_mem_wdata,
  output logic [WIDTH-1:0] inst_mem_rdata,
  output logic             inst_mem_resp,
  input  logic             data_mem_read,
  input  logic             data_mem_write,
  input  logic [1:0]       data_mem_byte_enable,
  input  logic [WIDTH-1:0] data_mem_addr,
  input  logic [WIDTH-1:0] data_mem_wdata,
  output logic [WIDTH-1:0] data_mem_rdata,
  output logic             data_mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [1:0]       pmem_wmask,
  output logic [WIDTH-1:0] pmem_address,
  output logic [WIDTH-1:0] pmem_wdata,
  input  logic [WIDTH-1:0] pmem_rdata,
  input  logic             pmem_resp
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, RESP} state_t;

  state_t           state_q, state_d;
  logic             i_v_q, i_v_d, i_w_q, i_w_d;
  logic [1:0]       i_be_q, i_be_d;
  logic [WIDTH-1:0] i_addr_q, i_addr_d, i_wdata_q, i_wdata_d, i_rdata_q, i_rdata_d;
  logic             d_v_q, d_v_d, d_w_q, d_w_d;
  logic [1:0]       d_be_q, d_be_d;
  logic [WIDTH-1:0] d_addr_q, d_addr_d, d_wdata_q, d_wdata_d, d_rdata_q, d_rdata_d;
  logic             srv_data_q, srv_data_d;
  logic             gap_q, gap_d;

  logic             inst_req, data_req, act, srv_w, other_pending;
  logic [1:0]       srv_be;
  logic [WIDTH-1:0] srv_addr, srv_wdata;

  assign inst_req = inst_mem_read | inst_mem_write;
  assign data_req = data_mem_read | data_mem_write;

  // gap_q holds the strobe low for the first SECOND cycle so accesses never abut
  always_comb begin
    srv_w         = srv_data_q ? d_w_q     : i_w_q;
    srv_be        = srv_data_q ? d_be_q    : i_be_q;
    srv_addr      = srv_data_q ? d_addr_q  : i_addr_q;
    srv_wdata     = srv_data_q ? d_wdata_q : i_wdata_q;
    other_pending = srv_data_q ? i_v_q     : d_v_q;
    act           = (state_q == FIRST) || ((state_q == SECOND) && !gap_q);
    pmem_read     = act && !srv_w;
    pmem_write    = act && srv_w;
    pmem_wmask    = act ? (srv_w ? srv_be : 2'b11) : 2'b00;
    pmem_address  = act ? srv_addr  : '0;
    pmem_wdata    = act ? srv_wdata : '0;
  end

  assign inst_mem_resp  = (state_q == RESP) && i_v_q;
  assign data_mem_resp  = (state_q == RESP) && d_v_q;
  assign inst_mem_rdata = i_rdata_q;
  assign data_mem_rdata = d_rdata_q;

  always_comb begin
    state_d    = state_q;
    i_v_d      = i_v_q;
    i_w_d      = i_w_q;
    i_be_d     = i_be_q;
    i_addr_d   = i_addr_q;
    i_wdata_d  = i_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_v_d      = d_v_q;
    d_w_d      = d_w_q;
    d_be_d     = d_be_q;
    d_addr_d   = d_addr_q;
    d_wdata_d  = d_wdata_q;
    d_rdata_d  = d_rdata_q;
    srv_data_d = srv_data_q;
    gap_d      = gap_q;

    if (act && pmem_resp && !srv_w) begin
      if (srv_data_q) d_rdata_d = pmem_rdata;
      else            i_rdata_d = pmem_rdata;
    end

    case (state_q)
      IDLE: begin
        i_v_d = inst_req;
        d_v_d = data_req;
        if (inst_req) begin
          i_w_d     = inst_mem_write;
          i_be_d    = inst_mem_byte_enable;
          i_addr_d  = inst_mem_addr;
          i_wdata_d = inst_mem_wdata;
        end
        if (data_req) begin
          d_w_d     = data_mem_write;
          d_be_d    = data_mem_byte_enable;
          d_addr_d  = data_mem_addr;
          d_wdata_d = data_mem_wdata;
        end
        if (inst_req || data_req) begin
          state_d    = FIRST;
          srv_data_d = data_req && (DATA_FIRST || !inst_req);
          gap_d      = 1'b0;
        end
      end
      FIRST: begin
        if (pmem_resp) begin
          if (other_pending) begin
            state_d    = SECOND;
            srv_data_d = !srv_data_q;
            gap_d      = 1'b1;
          end else begin
            state_d = RESP;
          end
        end
      end
      SECOND: begin
        gap_d = 1'b0;
        if (!gap_q && pmem_resp) state_d = RESP;
      end
      RESP: begin
        i_v_d   = 1'b0;
        d_v_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_v_q      <= 1'b0;
      i_w_q      <= 1'b0;
      i_be_q     <= '0;
      i_addr_q   <= '0;
      i_wdata_q  <= '0;
      i_rdata_q  <= '0;
      d_v_q      <= 1'b0;
      d_w_q      <= 1'b0;
      d_be_q     <= '0;
      d_addr_q   <= '0;
      d_wdata_q  <= '0;
      d_rdata_q  <= '0;
      srv_data_q <= 1'b0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_v_q      <= i_v_d;
      i_w_q      <= i_w_d;
      i_be_q     <= i_be_d;
      i_addr_q   <= i_addr_d;
      i_wdata_q  <= i_wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_v_q      <= d_v_d;
      d_w_q      <= d_w_d;
      d_be_q     <= d_be_d;
      d_addr_q   <= d_addr_d;
      d_wdata_q  <= d_wdata_d;
      d_rdata_q  <= d_rdata_d;
      srv_data_q <= srv_data_d;
      gap_q      <= gap_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam bit DF0 = 1'b1;

  typedef struct {
    logic [1:0]  i_op;
    logic [1:0]  i_be;
    logic [15:0] i_addr;
    logic [15:0] i_wdata;
    logic [1:0]  d_op;
    logic [1:0]  d_be;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    int          lat_a;
    int          lat_b;
    logic [15:0] exp_i_rdata;
    logic [15:0] exp_d_rdata;
    int          exp_cycles;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        inst_mem_read = 0, inst_mem_write = 0;
  logic [1:0]  inst_mem_byte_enable = 0;
  logic [15:0] inst_mem_addr = 0, inst_mem_wdata = 0;
  logic        data_mem_read = 0, data_mem_write = 0;
  logic [1:0]  data_mem_byte_enable = 0;
  logic [15:0] data_mem_addr = 0, data_mem_wdata = 0;
  logic [15:0] inst_mem_rdata, data_mem_rdata;
  logic        inst_mem_resp, data_mem_resp;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_address, pmem_wdata, pmem_rdata;

  logic [15:0] p1_inst_rdata, p1_data_rdata;
  logic        p1_inst_resp, p1_data_resp;
  logic        p1_read, p1_write, p1_resp;
  logic [1:0]  p1_wmask;
  logic [15:0] p1_address, p1_wdata, p1_rdata;

  int   lat_a = 1, lat_b = 1;
  logic force_resp = 1'b0;
  int   pass_cnt = 0, total_cnt = 0;

  mem_port_arbiter #(.WIDTH(16), .DATA_FIRST(DF0)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_mem_read(inst_mem_read), .inst_mem_write(inst_mem_write),
    .inst_mem_byte_enable(inst_mem_byte_enable), .inst_mem_addr(inst_mem_addr),
    .inst_mem_wdata(inst_mem_wdata), .inst_mem_rdata(inst_mem_rdata), .inst_mem_resp(inst_mem_resp),
    .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
    .data_mem_byte_enable(data_mem_byte_enable), .data_mem_addr(data_mem_addr),
    .data_mem_wdata(data_mem_wdata), .data_mem_rdata(data_mem_rdata), .data_mem_resp(data_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  mem_port_arbiter #(.WIDTH(16), .DATA_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .inst_mem_read(inst_mem_read), .inst_mem_write(inst_mem_write),
    .inst_mem_byte_enable(inst_mem_byte_enable), .inst_mem_addr(inst_mem_addr),
    .inst_mem_wdata(inst_mem_wdata), .inst_mem_rdata(p1_inst_rdata), .inst_mem_resp(p1_inst_resp),
    .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
    .data_mem_byte_enable(data_mem_byte_enable), .data_mem_addr(data_mem_addr),
    .data_mem_wdata(data_mem_wdata), .data_mem_rdata(p1_data_rdata), .data_mem_resp(p1_data_resp),
    .pmem_read(p1_read), .pmem_write(p1_write), .pmem_wmask(p1_wmask),
    .pmem_address(p1_address), .pmem_wdata(p1_wdata), .pmem_rdata(p1_rdata), .pmem_resp(p1_resp)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    case (a)
      16'h0040: init_val = 16'h1234;
      16'h2000: init_val = 16'hBEEF;
      16'h0042: init_val = 16'h6021;
      default:  init_val = {a[7:0], a[15:8]} ^ 16'hC3C3;
    endcase
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd, input logic [1:0] m);
    merge = {m[1] ? wd[15:8] : old[15:8], m[0] ? wd[7:0] : old[7:0]};
  endfunction

  // physical memory behind dut: fixed per-access latency counted in strobe cycles
  logic [15:0] mem0 [0:65535];
  bit          written0 [0:65535];
  int          cnt0, acc0, cur_lat0, b2b_cnt = 0, log_wr = 0, log_rd = 0;
  logic        strobe0, auto0, prev_resp0;
  logic [15:0] log_addr [0:1023];
  logic [15:0] log_wdata [0:1023];
  logic [1:0]  log_mask [0:1023];
  logic        log_w [0:1023];

  assign strobe0    = pmem_read | pmem_write;
  assign cur_lat0   = (acc0 == 0) ? lat_a : lat_b;
  assign auto0      = strobe0 && (cnt0 == cur_lat0 - 1);
  assign pmem_resp  = auto0 | force_resp;
  assign pmem_rdata = written0[pmem_address] ? mem0[pmem_address] : init_val(pmem_address);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 0; acc0 <= 0; prev_resp0 <= 1'b0;
    end else begin
      if (strobe0 && prev_resp0) b2b_cnt <= b2b_cnt + 1;
      prev_resp0 <= strobe0 && pmem_resp;
      if (inst_mem_resp | data_mem_resp) acc0 <= 0;
      if (strobe0 && pmem_resp) begin
        cnt0 <= 0;
        acc0 <= acc0 + 1;
        log_addr[log_wr]  <= pmem_address;
        log_w[log_wr]     <= pmem_write;
        log_mask[log_wr]  <= pmem_wmask;
        log_wdata[log_wr] <= pmem_wdata;
        log_wr <= log_wr + 1;
        if (pmem_write) begin
          written0[pmem_address] <= 1'b1;
          mem0[pmem_address] <= merge(pmem_rdata, pmem_wdata, pmem_wmask);
        end
      end else if (strobe0) cnt0 <= cnt0 + 1;
    end
  end

  int          cnt1, acc1, cur_lat1;
  logic        strobe1;
  logic [15:0] first1_addr;
  assign strobe1  = p1_read | p1_write;
  assign cur_lat1 = (acc1 == 0) ? lat_a : lat_b;
  assign p1_resp  = (strobe1 && (cnt1 == cur_lat1 - 1)) | force_resp;
  assign p1_rdata = p1_address ^ 16'h0F0F;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= 0; acc1 <= 0; first1_addr <= 16'h0;
    end else begin
      if (p1_inst_resp | p1_data_resp) acc1 <= 0;
      if (strobe1 && p1_resp) begin
        cnt1 <= 0;
        acc1 <= acc1 + 1;
        if (acc1 == 0) first1_addr <= p1_address;
      end else if (strobe1) cnt1 <= cnt1 + 1;
    end
  end

  // reference model: a flat memory updated in service order, plus the two rdata buffers
  logic [15:0] ref_mem [0:65535];
  bit          ref_written [0:65535];
  logic [15:0] ref_i_rdata = 16'h0, ref_d_rdata = 16'h0;
  logic [15:0] ex_addr [0:1];
  logic [15:0] ex_wdata [0:1];
  logic [1:0]  ex_mask [0:1];
  logic        ex_w [0:1];
  int          ex_n;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic model_txn(input vec_t v, output int ncyc, output bit iv, output bit dv);
    bit          pd, w;
    logic [15:0] a, wd, old;
    logic [1:0]  be;
    iv = (v.i_op != 2'b00);
    dv = (v.d_op != 2'b00);
    ex_n = 0;
    for (int s = 0; s < 2; s++) begin
      pd = (s == 0) ? DF0 : !DF0;
      if (pd ? dv : iv) begin
        w  = pd ? v.d_op[1] : v.i_op[1];
        a  = pd ? v.d_addr  : v.i_addr;
        wd = pd ? v.d_wdata : v.i_wdata;
        be = pd ? v.d_be    : v.i_be;
        old = ref_written[a] ? ref_mem[a] : init_val(a);
        ex_addr[ex_n]  = a;
        ex_w[ex_n]     = w;
        ex_mask[ex_n]  = w ? be : 2'b11;
        ex_wdata[ex_n] = wd;
        ex_n++;
        if (w) begin
          ref_mem[a] = merge(old, wd, be);
          ref_written[a] = 1'b1;
        end else if (pd) ref_d_rdata = old;
        else ref_i_rdata = old;
      end
    end
    ncyc = (ex_n == 1) ? v.lat_a + 1 : v.lat_a + v.lat_b + 2;
  endtask

  task automatic run_txn(input vec_t v, input bit from_model);
    int          mc, ec, k, strobes, exp_strobes;
    bit          iv, dv, got;
    logic [15:0] ei, ed;
    model_txn(v, mc, iv, dv);
    ei = from_model ? ref_i_rdata : v.exp_i_rdata;
    ed = from_model ? ref_d_rdata : v.exp_d_rdata;
    ec = from_model ? mc : v.exp_cycles;
    exp_strobes = (ex_n == 2) ? v.lat_a + v.lat_b : v.lat_a;
    @(negedge clk);
    lat_a = v.lat_a; lat_b = v.lat_b;
    inst_mem_read = v.i_op[0]; inst_mem_write = v.i_op[1];
    inst_mem_byte_enable = v.i_be; inst_mem_addr = v.i_addr; inst_mem_wdata = v.i_wdata;
    data_mem_read = v.d_op[0]; data_mem_write = v.d_op[1];
    data_mem_byte_enable = v.d_be; data_mem_addr = v.d_addr; data_mem_wdata = v.d_wdata;
    got = 0; strobes = 0;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (pmem_read | pmem_write) strobes++;
      if (inst_mem_resp | data_mem_resp) begin
        got = 1;
        break;
      end
    end
    chk("resp_cycle", k, ec);
    chk("inst_resp", inst_mem_resp, iv);
    chk("data_resp", data_mem_resp, dv);
    chk("inst_rdata", inst_mem_rdata, ei);
    chk("data_rdata", data_mem_rdata, ed);
    chk("strobe_cycles", strobes, exp_strobes);
    chk("df0_inst_resp", p1_inst_resp, iv);
    chk("df0_data_resp", p1_data_resp, dv);
    chk("df0_first_addr", first1_addr, iv ? v.i_addr : v.d_addr);
    chk("access_count", log_wr - log_rd, ex_n);
    for (int j = 0; j < ex_n; j++) begin
      chk("access_addr", log_addr[log_rd + j], ex_addr[j]);
      chk("access_write", log_w[log_rd + j], ex_w[j]);
      chk("access_mask", log_mask[log_rd + j], ex_mask[j]);
      if (ex_w[j]) chk("access_wdata", log_wdata[log_rd + j], ex_wdata[j]);
    end
    chk("no_back_to_back", b2b_cnt, 0);
    log_rd = log_wr;
    if (!got) $display("FAIL resp_timeout: got none expected resp within 200 cycles");
    inst_mem_read = 0; inst_mem_write = 0; data_mem_read = 0; data_mem_write = 0;
  endtask

  function automatic vec_t mk(input logic [1:0] iop, input logic [1:0] ibe, input logic [15:0] ia,
                              input logic [15:0] iwd, input logic [1:0] dop, input logic [1:0] dbe,
                              input logic [15:0] da, input logic [15:0] dwd, input int la, input int lb,
                              input logic [15:0] ei, input logic [15:0] ed, input int ec);
    vec_t v;
    v.i_op = iop; v.i_be = ibe; v.i_addr = ia; v.i_wdata = iwd;
    v.d_op = dop; v.d_be = dbe; v.d_addr = da; v.d_wdata = dwd;
    v.lat_a = la; v.lat_b = lb;
    v.exp_i_rdata = ei; v.exp_d_rdata = ed; v.exp_cycles = ec;
    return v;
  endfunction

  vec_t vecs [0:6];
  vec_t rv;

  initial begin
    int k, seen;
    // op bit0 = read, bit1 = write
    vecs[0] = mk(2'b01, 2'b11, 16'h0040, 16'h0000, 2'b00, 2'b11, 16'h0000, 16'h0000, 3, 1, 16'h1234, 16'h0000, 4);
    vecs[1] = mk(2'b01, 2'b11, 16'h0042, 16'h0000, 2'b01, 2'b11, 16'h2000, 16'h0000, 2, 3, 16'h6021, 16'hBEEF, 7);
    vecs[2] = mk(2'b01, 2'b11, 16'h0042, 16'h0000, 2'b10, 2'b10, 16'h3001, 16'h5A00, 1, 2, 16'h6021, 16'hBEEF, 5);
    vecs[3] = mk(2'b00, 2'b11, 16'h0000, 16'h0000, 2'b10, 2'b00, 16'h3001, 16'hFFFF, 2, 1, 16'h6021, 16'hBEEF, 3);
    vecs[4] = mk(2'b00, 2'b11, 16'h0000, 16'h0000, 2'b01, 2'b11, 16'h3001, 16'h0000, 1, 1, 16'h6021, 16'h5AF3, 2);
    vecs[5] = mk(2'b11, 2'b01, 16'h0100, 16'h12AA, 2'b01, 2'b11, 16'h0100, 16'h0000, 2, 1, 16'h6021, 16'hC3C2, 5);
    vecs[6] = mk(2'b01, 2'b11, 16'h0100, 16'h0000, 2'b00, 2'b11, 16'h0000, 16'h0000, 4, 1, 16'hC3AA, 16'hC3C2, 5);

    repeat (2) @(negedge clk);
    chk("reset_pmem_read", pmem_read, 0);
    chk("reset_pmem_write", pmem_write, 0);
    chk("reset_pmem_wmask", pmem_wmask, 0);
    chk("reset_pmem_address", pmem_address, 0);
    chk("reset_pmem_wdata", pmem_wdata, 0);
    chk("reset_resps", {inst_mem_resp, data_mem_resp}, 0);
    chk("reset_rdata", {inst_mem_rdata, data_mem_rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_strobe", strobe0, 0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], 1'b0);

    // request held through RESP: one IDLE cycle, then a single fresh capture
    @(negedge clk);
    lat_a = 1; lat_b = 1;
    inst_mem_read = 1; inst_mem_addr = 16'h0040;
    for (k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (inst_mem_resp) break;
    end
    chk("hold_first_resp_cycle", k, 2);
    @(negedge clk);
    chk("hold_idle_resp", inst_mem_resp, 0);
    chk("hold_idle_strobe", pmem_read, 0);
    @(negedge clk);
    chk("hold_resample_strobe", pmem_read, 1);
    inst_mem_read = 0;
    @(negedge clk);
    chk("hold_second_resp", inst_mem_resp, 1);
    chk("hold_second_rdata", inst_mem_rdata, 16'h1234);
    @(negedge clk);
    chk("hold_no_double_resp", inst_mem_resp, 0);
    ref_i_rdata = 16'h1234;
    log_rd = log_wr;

    // reset during FIRST with the read strobe up
    @(negedge clk);
    lat_a = 20;
    inst_mem_read = 1; inst_mem_addr = 16'h0100;
    repeat (2) @(negedge clk);
    chk("pre_reset_strobe", pmem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_strobe_drop", pmem_read, 0);
    chk("async_resp_low", {inst_mem_resp, data_mem_resp}, 0);
    inst_mem_read = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_i_rdata = 16'h0; ref_d_rdata = 16'h0;
    chk("post_reset_rdata", inst_mem_rdata, 0);
    k = log_wr;
    force_resp = 1'b1;
    @(negedge clk);
    force_resp = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (inst_mem_resp | data_mem_resp | strobe0) seen++;
    end
    chk("late_resp_ignored", seen, 0);
    chk("late_resp_no_access", log_wr - k, 0);
    log_rd = log_wr;
    run_txn(mk(2'b01, 2'b11, 16'h0100, 16'h0, 2'b00, 2'b11, 16'h0, 16'h0, 2, 1, 16'h0, 16'h0, 0), 1'b1);

    for (int n = 0; n < 40; n++) begin
      rv = mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'h0400 + 16'($urandom_range(0, 3)),
              16'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              16'h0400 + 16'($urandom_range(0, 3)), 16'($urandom),
              int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 16'h0, 16'h0, 0);
      if (rv.i_op == 2'b00 && rv.d_op == 2'b00) rv.d_op = 2'b01;
      run_txn(rv, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Responder for the CPU's two memory ports (instruction and data). It serialises them onto a single physical memory port.
- Every request present at the same sampling point completes together: all captured ports see their resp asserted in one common cycle. This matches the pipeline's need for inst and data resp to coincide.
- Sits between the CPU and the physical memory or cache.

Parameters:
WIDTH, 16, address and data width in bits
DATA_FIRST, 1, 1 = serve the data port before the inst port when both are captured; 0 = inst first

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
inst_mem_read  in  1  inst read request; held until inst_mem_resp
inst_mem_write  in  1  inst write request; held until inst_mem_resp
inst_mem_byte_enable  in  2  inst write mask: 01 low byte, 10 high byte, 11 word
inst_mem_addr  in  WIDTH  inst address
inst_mem_wdata  in  WIDTH  inst write data
inst_mem_rdata  out  WIDTH  inst read data
inst_mem_resp  out  1  inst completion, one-cycle pulse
data_mem_read  in  1  data read request
data_mem_write  in  1  data write request
data_mem_byte_enable  in  2  data write mask, same encoding as the inst port
data_mem_addr  in  WIDTH  data address
data_mem_wdata  in  WIDTH  data write data
data_mem_rdata  out  WIDTH  data read data
data_mem_resp  out  1  data completion, one-cycle pulse
pmem_read  out  1  physical read strobe
pmem_write  out  1  physical write strobe
pmem_wmask  out  2  physical byte mask
pmem_address  out  WIDTH  physical address
pmem_wdata  out  WIDTH  physical write data
pmem_rdata  in  WIDTH  physical read data; valid in the pmem_resp cycle
pmem_resp  in  1  physical completion pulse, latency of 1 or more cycles

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state goes to IDLE;
  - all capture registers and both rdata buffers are cleared to 0;
  - pmem_read, pmem_write, inst_mem_resp and data_mem_resp drop to 0 immediately;
  - pmem_wmask, pmem_address and pmem_wdata are 0.
  - Reset mid-access abandons the access. A pmem_resp arriving after release is ignored.
- A port is requesting when its read or write input is 1. If read and write are both 1, it is treated as a write.
- States: IDLE, FIRST, SECOND, RESP.
- IDLE:
  - Sample both ports. For each requesting port, capture a valid flag, op, address, wdata and mask.
  - If no port is requesting, stay in IDLE.
  - Otherwise go to FIRST, serving the DATA_FIRST-preferred captured port. If only one port is captured, serve that port.
- FIRST / SECOND:
  - pmem outputs are driven combinationally from the served port's capture registers.
  - pmem_read / pmem_write stay held until pmem_resp.
  - pmem_wmask is the captured mask on writes and 11 on reads.
  - On pmem_resp:
    - for reads, latch pmem_rdata into that port's rdata buffer;
    - for writes, the buffer is unchanged.
  - Then go to SECOND if the other port is captured and not yet served; otherwise go to RESP.
  - Strobes deassert in the cycle after pmem_resp. There is no back-to-back strobe without at least one low cycle.
- RESP:
  - Assert resp for every captured port in this single cycle.
  - Clear the capture valid flags and return to IDLE.
  - Requests are not sampled in RESP. This gives the CPU pipeline registers one edge to update before IDLE re-samples.
- rdata outputs come directly from the buffers. They are stable from RESP until the next read completion on that port.
- Resp is never asserted outside RESP.
- Latency, from the first IDLE sample to the resp cycle, with pmem latency L:
  - single port: 1 + L + 1 cycles;
  - both ports: 1 + L1 + 1 + L2 + 1 cycles.
- Request inputs are ignored while busy, so changes mid-transaction have no effect. The captured copy is used.
- pmem_resp in IDLE or RESP is ignored.
- A mask of 00 on a write passes through unchanged.

Test Plan:
- Reset, then inst read only at 0x0040; pmem returns 0x1234 after 2 cycles:
  - pmem_read high for 3 cycles at 0x0040;
  - inst_mem_resp pulses once with inst_mem_rdata = 0x1234;
  - data_mem_resp stays 0.
- Both ports: data read at 0x2000 (pmem returns 0xBEEF), inst read at 0x0042 (pmem returns 0x6021), DATA_FIRST=1:
  - pmem accesses 0x2000 then 0x0042, with one idle strobe cycle between them;
  - both resps pulse in the same cycle with 0xBEEF and 0x6021.
- Data write at 0x3001, mask 10, wdata 0x5A00, plus an inst read:
  - pmem_write at 0x3001 with wmask 10 and wdata 0x5A00;
  - data_mem_rdata is unchanged from its prior value;
  - both resps pulse together.
- DATA_FIRST=0 with both ports requesting -> the inst access is issued first, and the resps still coincide.
- rst_n pulled low during FIRST with pmem_read high:
  - pmem_read drops asynchronously;
  - a late pmem_resp produces no CPU resp;
  - the next request completes normally.
- Request held continuously across RESP -> exactly one IDLE cycle follows RESP before the re-sample, and there is no double resp for a single capture.
